// File: rtl/inst_mem_ctl.sv
// Writable instruction memory for the fetch stage: self-clears after reset, accepts a
// sequential program load, and serves one-cycle-latency fetches with stall hold.
module inst_mem_ctl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              stall,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst,
    output logic              addr_err,
    output logic              ready,
    input  logic              load_en,
    input  logic              load_wr,
    input  logic [DATA_W-1:0] load_data,
    output logic [ADDR_W:0]   load_cnt,
    output logic              load_full
);

    localparam logic [ADDR_W:0]   DepthCnt = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {StClear, StIdle, StLoad} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   clr_ptr_q;
    logic [ADDR_W:0]     load_cnt_q;
    logic [DATA_W-1:0]   inst_q;
    logic                inst_valid_q;
    logic                addr_err_q;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                in_range;
    logic                full;

    assign full     = (load_cnt_q == DepthCnt);
    // Constant-true when DEPTH fills the whole address space, so addr_err never fires.
    assign in_range = ({1'b0, fetch_addr} < DepthCnt);

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        unique case (state_q)
            StClear: mem_we = 1'b1;
            StLoad: begin
                if (load_wr && !full) begin
                    mem_we    = 1'b1;
                    mem_waddr = load_cnt_q[ADDR_W-1:0];
                    mem_wdata = load_data;
                end
            end
            default: mem_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StClear;
            clr_ptr_q    <= '0;
            load_cnt_q   <= '0;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            if (!stall) begin
                if (state_q == StIdle && fetch_req) begin
                    inst_valid_q <= 1'b1;
                    addr_err_q   <= !in_range;
                    inst_q       <= in_range ? mem_q[fetch_addr] : '0;
                end else begin
                    inst_valid_q <= 1'b0;
                    addr_err_q   <= 1'b0;
                end
            end
            unique case (state_q)
                StClear: begin
                    clr_ptr_q <= clr_ptr_q + 1'b1;
                    if (clr_ptr_q == LastIdx) begin
                        state_q <= StIdle;
                    end
                end
                StIdle: begin
                    if (load_en) begin
                        state_q    <= StLoad;
                        load_cnt_q <= '0;
                    end
                end
                StLoad: begin
                    if (load_wr && !full) begin
                        load_cnt_q <= load_cnt_q + 1'b1;
                    end
                    if (!load_en) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StClear;
            endcase
        end
    end

    assign ready      = (state_q == StIdle);
    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign addr_err   = addr_err_q;
    assign load_cnt   = load_cnt_q;
    assign load_full  = full;

endmodule

// File: tb/tb_inst_mem_ctl.sv
// Bench for inst_mem_ctl: a DEPTH=64 and a DEPTH=48 instance share stimulus and are checked
// every cycle against a word-level model, plus directed literal expectations.
module tb_inst_mem_ctl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic [5:0]  fetch_addr = '0;
    logic        stall = 1'b0;
    logic        load_en = 1'b0;
    logic        load_wr = 1'b0;
    logic [31:0] load_data = '0;

    logic        valid_a, err_a, ready_a, full_a;
    logic [31:0] inst_a;
    logic [6:0]  cnt_a;
    logic        valid_b, err_b, ready_b, full_b;
    logic [31:0] inst_b;
    logic [6:0]  cnt_b;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    inst_mem_ctl #(.DATA_W(32), .ADDR_W(6), .DEPTH(64)) u_a (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .stall(stall), .inst_valid(valid_a), .inst(inst_a), .addr_err(err_a),
        .ready(ready_a), .load_en(load_en), .load_wr(load_wr), .load_data(load_data),
        .load_cnt(cnt_a), .load_full(full_a)
    );

    inst_mem_ctl #(.DATA_W(32), .ADDR_W(6), .DEPTH(48)) u_b (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .stall(stall), .inst_valid(valid_b), .inst(inst_b), .addr_err(err_b),
        .ready(ready_b), .load_en(load_en), .load_wr(load_wr), .load_data(load_data),
        .load_cnt(cnt_b), .load_full(full_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: mode 0 = clearing, 1 = idle, 2 = loading. Clearing is modelled as an
    // all-zero array plus a countdown, since nothing can read or write during it.
    int          dep [2] = '{64, 48};
    int          mode [2];
    int          clr_left [2];
    int          lcnt [2];
    logic [31:0] mem_m [2][64];
    logic [31:0] m_inst [2];
    logic        m_valid [2];
    logic        m_err [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mode[k] = 0; clr_left[k] = dep[k]; lcnt[k] = 0;
            m_inst[k] = '0; m_valid[k] = 1'b0; m_err[k] = 1'b0;
            for (int i = 0; i < 64; i++) mem_m[k][i] = '0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (!stall) begin
                if (mode[k] == 1 && fetch_req) begin
                    m_valid[k] = 1'b1;
                    if (int'(fetch_addr) < dep[k]) begin
                        m_inst[k] = mem_m[k][fetch_addr]; m_err[k] = 1'b0;
                    end else begin
                        m_inst[k] = '0; m_err[k] = 1'b1;
                    end
                end else begin
                    m_valid[k] = 1'b0; m_err[k] = 1'b0;
                end
            end
            if (mode[k] == 0) begin
                clr_left[k]--;
                if (clr_left[k] == 0) mode[k] = 1;
            end else if (mode[k] == 1) begin
                if (load_en) begin mode[k] = 2; lcnt[k] = 0; end
            end else begin
                if (load_wr && lcnt[k] < dep[k]) begin
                    mem_m[k][lcnt[k]] = load_data; lcnt[k]++;
                end
                if (!load_en) mode[k] = 1;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("a.ready", 64'(ready_a), 64'(mode[0] == 1));
                check("a.valid", 64'(valid_a), 64'(m_valid[0]));
                check("a.err",   64'(err_a),   64'(m_err[0]));
                check("a.inst",  64'(inst_a),  64'(m_inst[0]));
                check("a.cnt",   64'(cnt_a),   64'(lcnt[0]));
                check("a.full",  64'(full_a),  64'(lcnt[0] == 64));
                check("b.ready", 64'(ready_b), 64'(mode[1] == 1));
                check("b.valid", 64'(valid_b), 64'(m_valid[1]));
                check("b.err",   64'(err_b),   64'(m_err[1]));
                check("b.inst",  64'(inst_b),  64'(m_inst[1]));
                check("b.cnt",   64'(cnt_b),   64'(lcnt[1]));
                check("b.full",  64'(full_b),  64'(lcnt[1] == 48));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [5:0] a);
        fetch_req = 1'b1; fetch_addr = a;
        cyc();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".ready"}, 64'(ready_a), 64'd0);
        check({tag, ".valid"}, 64'(valid_a), 64'd0);
        check({tag, ".inst"},  64'(inst_a),  64'd0);
        check({tag, ".err"},   64'(err_a),   64'd0);
        check({tag, ".cnt"},   64'(cnt_a),   64'd0);
        check({tag, ".full"},  64'(full_a),  64'd0);
    endtask

    task automatic wait_clear(input string tag);
        int n = 0;
        while (!ready_a && n < 200) begin cyc(); n++; end
        check({tag, ".clear_cycles"}, 64'(n), 64'd64);
    endtask

    logic [31:0] prog [4] = '{32'h0000_0000, 32'h0004_1143, 32'h0404_2025, 32'h0447_3005};

    initial begin
        #12;
        check_reset_vals("rst0");
        rst_n = 1'b1;
        wait_clear("clr0");

        for (int a = 0; a < 64; a++) begin
            fetch(6'(a));
            if (a == 0 || a == 63) begin
                check("sweep.inst", 64'(inst_a), 64'd0);
                check("sweep.err", 64'(err_a), 64'd0);
            end
        end

        fetch_req = 1'b0; load_en = 1'b1;
        cyc();
        check("load_entry.ready", 64'(ready_a), 64'd0);
        for (int i = 0; i < 4; i++) begin
            load_wr = 1'b1; load_data = prog[i];
            cyc();
        end
        load_wr = 1'b0; load_en = 1'b0;
        cyc();
        check("load_exit.ready", 64'(ready_a), 64'd1);
        check("load4.cnt", 64'(cnt_a), 64'd4);

        fetch(6'd1);
        check("bb1.inst", 64'(inst_a), 64'h0004_1143);
        fetch(6'd2);
        check("bb2.inst", 64'(inst_a), 64'h0404_2025);
        fetch(6'd3);
        check("bb3.inst", 64'(inst_a), 64'h0447_3005);
        check("bb3.valid", 64'(valid_a), 64'd1);

        fetch(6'h2F);
        check("d48_2f.err", 64'(err_b), 64'd0);
        fetch(6'h30);
        check("d48_30.err", 64'(err_b), 64'd1);
        check("d48_30.inst", 64'(inst_b), 64'd0);
        check("d64_30.err", 64'(err_a), 64'd0);
        fetch(6'h3F);
        check("d48_3f.err", 64'(err_b), 64'd1);

        fetch(6'd2);
        check("stall_pre.inst", 64'(inst_a), 64'h0404_2025);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch_req = i[0]; fetch_addr = 6'(i + 1);
            cyc();
            check("stall.inst", 64'(inst_a), 64'h0404_2025);
            check("stall.valid", 64'(valid_a), 64'd1);
        end
        stall = 1'b0;
        fetch(6'd3);
        check("unstall.inst", 64'(inst_a), 64'h0447_3005);
        fetch_req = 1'b0;
        cyc();
        check("idle.valid", 64'(valid_a), 64'd0);

        load_en = 1'b1;
        cyc();
        for (int i = 0; i < 70; i++) begin
            load_wr = 1'b1; load_data = 32'hA000_0000 + 32'(i);
            fetch_req = 1'b1; fetch_addr = 6'(i % 64);
            cyc();
            if (i == 5) check("load_fetch.valid", 64'(valid_a), 64'd0);
        end
        check("full.cnt", 64'(cnt_a), 64'd64);
        check("full.flag", 64'(full_a), 64'd1);
        check("full48.cnt", 64'(cnt_b), 64'd48);
        load_wr = 1'b0; load_en = 1'b0; fetch_req = 1'b0;
        cyc();
        for (int a = 0; a < 64; a++) fetch(6'(a));
        check("full.last", 64'(inst_a), 64'hA000_003F);
        fetch(6'd0);
        check("full.first", 64'(inst_a), 64'hA000_0000);
        check("full.cnt_hold", 64'(cnt_a), 64'd64);

        fetch_req = 1'b0; load_en = 1'b1;
        cyc();
        for (int i = 0; i < 10; i++) begin
            load_wr = 1'b1; load_data = 32'h5555_0000 + 32'(i);
            cyc();
        end
        check("mid.cnt", 64'(cnt_a), 64'd10);
        load_wr = 1'b0; load_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst1");
        #1;
        rst_n = 1'b1;
        wait_clear("clr1");
        fetch(6'd5);
        check("post_rst.inst", 64'(inst_a), 64'd0);
        check("post_rst.valid", 64'(valid_a), 64'd1);
        fetch_req = 1'b0;
        cyc();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
